// File: rtl/sdr_dq_responder_pkg.sv
// Shared command encodings, burst state and mode-register helper for the SDRAM data-path responder.
// Commands are the {CSn, RASn, CASn, WEn} strobes sampled on the rising edge.
package sdr_dq_responder_pkg;

   localparam logic [3:0] C_LMR = 4'b0000;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_BST = 4'b0110;
   localparam logic [3:0] C_NOP = 4'b0111;

   typedef enum logic [1:0] {
      BST_IDLE = 2'd0,
      BST_WR   = 2'd1,
      BST_RD   = 2'd2
   } burst_st_e;

   function automatic logic cl_ok(input logic [2:0] cl);
      return (cl == 3'd2) || (cl == 3'd3);
   endfunction

endpackage

// File: rtl/sdr_dq_responder_if.sv
// SDRAM command pins plus the responder's status flags; the controller side is master.
interface sdr_dq_responder_if;
   logic        sdr_CSn;
   logic        sdr_RASn;
   logic        sdr_CASn;
   logic        sdr_WEn;
   logic [1:0]  sdr_BA;
   logic [11:0] sdr_A;
   logic        cmd_err;
   logic        row_open;

   modport master (
      output sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A,
      input  cmd_err, row_open
   );

   modport slave (
      input  sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn, sdr_BA, sdr_A,
      output cmd_err, row_open
   );
endinterface

// File: rtl/sdr_dq_responder_rd_pipe.sv
// Read-latency delay line: beats enter one per edge and reach the output tap CL-1 edges later.
// Two stages cover CL 2 and 3; the tap is chosen by the latency latched at the READ edge.
module sdr_dq_responder_rd_pipe #(
   parameter int unsigned BW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    cl_i,
   input  logic          in_vld_i,
   input  logic [BW+1:0] in_addr_i,
   output logic          out_vld_o,
   output logic [BW+1:0] out_addr_o
);

   typedef struct packed {
      logic          vld;
      logic [1:0]    beat;
      logic [BW-1:0] base;
   } rd_ent_t;

   rd_ent_t st0_q, st0_d;
   rd_ent_t st1_q, st1_d;
   rd_ent_t tap;

   always_comb begin
      st0_d      = '0;
      st0_d.vld  = in_vld_i;
      st0_d.beat = in_addr_i[1:0];
      st0_d.base = in_addr_i[BW+1:2];
      st1_d      = st0_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st0_q <= '0;
         st1_q <= '0;
      end else begin
         st0_q <= st0_d;
         st1_q <= st1_d;
      end
   end

   assign tap        = (cl_i == 3'd2) ? st0_q : st1_q;
   assign out_vld_o  = tap.vld;
   assign out_addr_o = {tap.base, tap.beat};

endmodule

// File: rtl/sdr_dq_responder.sv
// SDRAM-side responder: decodes commands, tracks open rows, stores 4-beat write bursts and returns reads after CAS latency.
// Outputs are registered; a READ/WRITE during a burst or to a closed bank is rejected with a one-cycle cmd_err.
module sdr_dq_responder
   import sdr_dq_responder_pkg::*;
#(
   parameter int unsigned ROW_W   = 4,
   parameter int unsigned COL_W   = 8,
   parameter int unsigned DEF_CAS = 3
) (
   input  logic               clk,
   input  logic               reset,
   sdr_dq_responder_if.slave  bus,
   inout  wire  [3:0]         sdr_DQ
);

   localparam int unsigned AW = 2 + ROW_W + COL_W;
   localparam int unsigned BW = AW - 2;

   logic [3:0]            cmd;
   logic [1:0]            ba;
   logic [BW-1:0]         cmd_base;

   logic [3:0]            open_q, open_d;
   logic [3:0][ROW_W-1:0] row_q, row_d;
   logic [2:0]            cl_q, cl_d;
   logic [2:0]            rd_cl_q, rd_cl_d;
   burst_st_e             st_q, st_d;
   logic [2:0]            busy_q, busy_d;
   logic [1:0]            beat_q, beat_d;
   logic [BW-1:0]         base_q, base_d;
   logic                  ap_q, ap_d;
   logic [1:0]            ap_bank_q, ap_bank_d;
   logic                  err_q, err_d;
   logic [3:0]            dq_q, dq_d;
   logic                  dq_en_q, dq_en_d;

   logic                  mem_we;
   logic [AW-1:0]         mem_waddr;
   logic                  iss_vld;
   logic [AW-1:0]         iss_addr;
   logic                  rd_vld;
   logic [AW-1:0]         rd_addr;
   logic                  unused_a;

   logic [3:0]            mem_q [2**AW];

   assign cmd      = {bus.sdr_CSn, bus.sdr_RASn, bus.sdr_CASn, bus.sdr_WEn};
   assign ba       = bus.sdr_BA;
   assign unused_a = ^bus.sdr_A;

   always_comb begin
      open_d    = open_q;
      row_d     = row_q;
      cl_d      = cl_q;
      rd_cl_d   = rd_cl_q;
      st_d      = st_q;
      busy_d    = busy_q;
      beat_d    = beat_q;
      base_d    = base_q;
      ap_d      = ap_q;
      ap_bank_d = ap_bank_q;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      iss_vld   = 1'b0;
      iss_addr  = '0;
      cmd_base  = {ba, row_q[ba], bus.sdr_A[COL_W-1:2]};

      // Beats 1..3 of the burst in flight; beat_q wraps to 0 once beat 3 is done.
      if (st_q != BST_IDLE) begin
         busy_d = busy_q - 3'd1;
         if (beat_q != 2'd0) begin
            beat_d = beat_q + 2'd1;
            if (st_q == BST_WR) begin
               mem_we    = 1'b1;
               mem_waddr = {base_q, beat_q};
            end else begin
               iss_vld  = 1'b1;
               iss_addr = {base_q, beat_q};
            end
         end
         if (busy_q == 3'd1) begin
            st_d = BST_IDLE;
            if (ap_q) begin
               open_d[ap_bank_q] = 1'b0;
            end
         end
      end

      if (!bus.sdr_CSn) begin
         case (cmd)
            C_NOP: ;
            C_ACT: begin
               if (open_q[ba]) begin
                  err_d = 1'b1;
               end else begin
                  open_d[ba] = 1'b1;
                  row_d[ba]  = bus.sdr_A[ROW_W-1:0];
               end
            end
            C_PRE: begin
               if (bus.sdr_A[10]) begin
                  open_d = '0;
               end else begin
                  open_d[ba] = 1'b0;
               end
            end
            C_LMR: begin
               if (cl_ok(bus.sdr_A[6:4])) begin
                  cl_d = bus.sdr_A[6:4];
               end else begin
                  err_d = 1'b1;
               end
            end
            C_REF: begin
               err_d = |open_q;
            end
            C_WR, C_RD: begin
               if ((st_q != BST_IDLE) || !open_q[ba]) begin
                  err_d = 1'b1;
               end else begin
                  base_d    = cmd_base;
                  beat_d    = 2'd1;
                  ap_d      = bus.sdr_A[10];
                  ap_bank_d = ba;
                  if (cmd == C_WR) begin
                     st_d      = BST_WR;
                     busy_d    = 3'd3;
                     mem_we    = 1'b1;
                     mem_waddr = {cmd_base, 2'd0};
                  end else begin
                     st_d     = BST_RD;
                     busy_d   = cl_q + 3'd3;
                     rd_cl_d  = cl_q;
                     iss_vld  = 1'b1;
                     iss_addr = {cmd_base, 2'd0};
                  end
               end
            end
            default: err_d = 1'b1;
         endcase
      end

      dq_en_d = rd_vld;
      dq_d    = rd_vld ? mem_q[rd_addr] : 4'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         open_q    <= '0;
         row_q     <= '0;
         cl_q      <= DEF_CAS[2:0];
         rd_cl_q   <= DEF_CAS[2:0];
         st_q      <= BST_IDLE;
         busy_q    <= '0;
         beat_q    <= '0;
         base_q    <= '0;
         ap_q      <= 1'b0;
         ap_bank_q <= '0;
         err_q     <= 1'b0;
         dq_q      <= '0;
         dq_en_q   <= 1'b0;
      end else begin
         open_q    <= open_d;
         row_q     <= row_d;
         cl_q      <= cl_d;
         rd_cl_q   <= rd_cl_d;
         st_q      <= st_d;
         busy_q    <= busy_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         ap_q      <= ap_d;
         ap_bank_q <= ap_bank_d;
         err_q     <= err_d;
         dq_q      <= dq_d;
         dq_en_q   <= dq_en_d;
      end
   end

   // Contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= sdr_DQ;
      end
   end

   sdr_dq_responder_rd_pipe #(
      .BW (BW)
   ) u_rd_pipe (
      .clk        (clk),
      .reset      (reset),
      .cl_i       (rd_cl_q),
      .in_vld_i   (iss_vld),
      .in_addr_i  (iss_addr),
      .out_vld_o  (rd_vld),
      .out_addr_o (rd_addr)
   );

   assign sdr_DQ       = dq_en_q ? dq_q : 4'bz;
   assign bus.cmd_err  = err_q;
   assign bus.row_open = |open_q;

endmodule

// File: tb/tb_sdr_dq_responder.sv
// Directed bench for sdr_dq_responder; the pulled-up DQ bus reads 4'hF whenever nobody drives it.
module tb_sdr_dq_responder;
   import sdr_dq_responder_pkg::*;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] tb_dq;
   logic       tb_dq_en;
   wire  [3:0] dq;
   int         n_chk = 0;
   int         n_err = 0;

   sdr_dq_responder_if sif ();

   sdr_dq_responder #(
      .ROW_W   (4),
      .COL_W   (8),
      .DEF_CAS (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (sif),
      .sdr_DQ (dq)
   );

   assign dq = tb_dq_en ? tb_dq : 4'bz;
   pullup (dq[0]);
   pullup (dq[1]);
   pullup (dq[2]);
   pullup (dq[3]);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents one command (and optional write nibble) for the next rising edge.
   task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [11:0] a,
                        input logic den, input logic [3:0] dat);
      {sif.sdr_CSn, sif.sdr_RASn, sif.sdr_CASn, sif.sdr_WEn} = c;
      sif.sdr_BA = ba;
      sif.sdr_A  = a;
      tb_dq_en   = den;
      tb_dq      = dat;
      @(negedge clk);
   endtask

   task automatic nop();
      drive(C_NOP, 2'd0, 12'h000, 1'b0, 4'h0);
   endtask

   task automatic write_burst(input logic [1:0] ba, input logic [11:0] a, input logic [15:0] d);
      drive(C_WR, ba, a, 1'b1, d[3:0]);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, d[7:4]);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, d[11:8]);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, d[15:12]);
   endtask

   // READ at edge N, then observe what the controller sees at edges N+1..N+8.
   // An optional command inj_c replaces the NOP at edge N+inj_m.
   task automatic read_chk(input string tag, input logic [1:0] ba, input logic [11:0] a,
                           input int cl, input logic [15:0] d, input logic rej,
                           input int inj_m, input logic [3:0] inj_c);
      logic [3:0] exp_dq;
      logic       exp_err;
      drive(C_RD, ba, a, 1'b0, 4'h0);
      for (int m = 1; m <= 8; m++) begin
         exp_dq = 4'hF;
         if (!rej && m >= cl && m < cl + 4) begin
            exp_dq = d[4*(m-cl) +: 4];
         end
         exp_err = rej ? (m == 1) : (m == inj_m + 1);
         check({tag, "_dq"}, {12'h0, dq}, {12'h0, exp_dq});
         check({tag, "_err"}, {15'h0, sif.cmd_err}, {15'h0, exp_err});
         if (m == inj_m) begin
            drive(inj_c, ba, a, 1'b0, 4'h0);
         end else begin
            nop();
         end
      end
   endtask

   initial begin
      tb_dq_en     = 1'b0;
      tb_dq        = 4'h0;
      sif.sdr_CSn  = 1'b1;
      sif.sdr_RASn = 1'b1;
      sif.sdr_CASn = 1'b1;
      sif.sdr_WEn  = 1'b1;
      sif.sdr_BA   = 2'd0;
      sif.sdr_A    = 12'h000;
      repeat (3) @(negedge clk);
      check("rst_dq", {12'h0, dq}, 16'hF);
      check("rst_err", {15'h0, sif.cmd_err}, 16'h0);
      check("rst_row_open", {15'h0, sif.row_open}, 16'h0);
      reset = 1'b0;
      @(negedge clk);

      // CL3 write/read round trip
      drive(C_LMR, 2'd0, 12'h030, 1'b0, 4'h0);
      check("lmr3_err", {15'h0, sif.cmd_err}, 16'h0);
      drive(C_ACT, 2'd0, 12'h005, 1'b0, 4'h0);
      check("act0_row_open", {15'h0, sif.row_open}, 16'h1);
      check("act0_err", {15'h0, sif.cmd_err}, 16'h0);
      write_burst(2'd0, 12'h010, 16'h1234);
      check("wr0_err", {15'h0, sif.cmd_err}, 16'h0);
      nop();
      read_chk("rd_cl3", 2'd0, 12'h010, 3, 16'h1234, 1'b0, 99, C_NOP);

      // CL2 repeat
      drive(C_LMR, 2'd0, 12'h020, 1'b0, 4'h0);
      check("lmr2_err", {15'h0, sif.cmd_err}, 16'h0);
      read_chk("rd_cl2", 2'd0, 12'h010, 2, 16'h1234, 1'b0, 99, C_NOP);

      // rejected commands
      read_chk("rd_closed", 2'd2, 12'h010, 2, 16'h0, 1'b1, 99, C_NOP);
      drive(C_REF, 2'd0, 12'h000, 1'b0, 4'h0);
      check("ref_open_err", {15'h0, sif.cmd_err}, 16'h1);
      drive(C_BST, 2'd0, 12'h000, 1'b0, 4'h0);
      check("bst_err", {15'h0, sif.cmd_err}, 16'h1);
      nop();
      check("err_clear", {15'h0, sif.cmd_err}, 16'h0);

      // collisions with a CL3 read in flight
      drive(C_LMR, 2'd0, 12'h030, 1'b0, 4'h0);
      read_chk("rd_wr_busy", 2'd0, 12'h010, 3, 16'h1234, 1'b0, 4, C_WR);
      read_chk("rd_rd_busy", 2'd0, 12'h010, 3, 16'h1234, 1'b0, 6, C_RD);
      read_chk("rd_after_busy", 2'd0, 12'h010, 3, 16'h1234, 1'b0, 99, C_NOP);

      // precharge, refresh with all banks closed, auto-precharge write
      drive(C_PRE, 2'd0, 12'h000, 1'b0, 4'h0);
      check("pre0_row_open", {15'h0, sif.row_open}, 16'h0);
      drive(C_REF, 2'd0, 12'h000, 1'b0, 4'h0);
      check("ref_closed_err", {15'h0, sif.cmd_err}, 16'h0);
      drive(C_ACT, 2'd1, 12'h002, 1'b0, 4'h0);
      check("act1_row_open", {15'h0, sif.row_open}, 16'h1);
      drive(C_WR, 2'd1, 12'h424, 1'b1, 4'h9);
      check("ap_b0_open", {15'h0, sif.row_open}, 16'h1);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, 4'h8);
      check("ap_b1_open", {15'h0, sif.row_open}, 16'h1);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, 4'h7);
      check("ap_b2_open", {15'h0, sif.row_open}, 16'h1);
      drive(C_NOP, 2'd0, 12'h000, 1'b1, 4'h6);
      check("ap_b3_closed", {15'h0, sif.row_open}, 16'h0);
      check("ap_wr_err", {15'h0, sif.cmd_err}, 16'h0);
      nop();
      read_chk("rd_after_ap", 2'd1, 12'h024, 3, 16'h0, 1'b1, 99, C_NOP);
      drive(C_ACT, 2'd1, 12'h002, 1'b0, 4'h0);
      check("act1b_err", {15'h0, sif.cmd_err}, 16'h0);
      drive(C_ACT, 2'd1, 12'h007, 1'b0, 4'h0);
      check("act_open_err", {15'h0, sif.cmd_err}, 16'h1);
      read_chk("rd_b1", 2'd1, 12'h024, 3, 16'h6789, 1'b0, 99, C_NOP);

      // reset during read beat 1
      drive(C_RD, 2'd1, 12'h024, 1'b0, 4'h0);
      nop();
      nop();
      check("mid_b0", {12'h0, dq}, 16'h9);
      nop();
      check("mid_b1", {12'h0, dq}, 16'h8);
      reset = 1'b1;
      #1;
      check("mid_rst_dq", {12'h0, dq}, 16'hF);
      check("mid_rst_row_open", {15'h0, sif.row_open}, 16'h0);
      check("mid_rst_err", {15'h0, sif.cmd_err}, 16'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(C_LMR, 2'd0, 12'h010, 1'b0, 4'h0);
      check("lmr1_err", {15'h0, sif.cmd_err}, 16'h1);
      nop();
      check("lmr1_err_clear", {15'h0, sif.cmd_err}, 16'h0);
      drive(C_ACT, 2'd0, 12'h005, 1'b0, 4'h0);
      read_chk("rd_post_rst", 2'd0, 12'h010, 3, 16'h1234, 1'b0, 99, C_NOP);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sdr_dq_responder.md
# sdr_dq_responder

SDRAM-side data-path responder for the x4 SDRAM interface driven by the controller's nibble data path. It decodes commands on the SDRAM pins, tracks open rows per bank, and captures 4-beat write bursts into a nibble array. It returns 4-beat read bursts on `sdr_DQ` after the programmed CAS latency. It is the memory end of the controller↔SDRAM link and is used in the UVM bench in place of a vendor model.

## Interface
- `ROW_W`, default 4: stored row-address bits per bank (low bits of `sdr_A`).
- `COL_W`, default 8: stored column bits. `col[1:0]` is ignored because bursts are aligned.
- `DEF_CAS`, default 3: CAS latency after reset.
- `tDLY`, default 1: output delay on `sdr_DQ` and flags.
- `clk` in 1: single clock; all sampling on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `sdr_CSn`, `sdr_RASn`, `sdr_CASn`, `sdr_WEn` in 1 each: command strobes.
- `sdr_BA` in 2: bank address.
- `sdr_A` in 12: row/column/mode address. `A10` selects auto-precharge or all-bank precharge.
- `sdr_DQ` inout 4: data nibble. Driven only during read beats, high-Z otherwise.
- `cmd_err` out 1: one-cycle pulse on an illegal or rejected command.
- `row_open` out 1: OR of the per-bank open flags.

## Operation
- Command decode `{CSn,RASn,CASn,WEn}` is sampled each edge:
  - 0111 = NOP.
  - 0011 = ACTIVE.
  - 0101 = READ.
  - 0100 = WRITE.
  - 0010 = PRECHARGE.
  - 0001 = AUTO_REFRESH.
  - 0000 = LOAD_MODE.
  - `CSn`=1 = deselect.
  - 0110 (burst terminate) is unsupported and raises `cmd_err`.
- ACTIVE: latches `A[ROW_W-1:0]` as the open row of bank `BA` and sets its open flag. ACTIVE to an already-open bank raises `cmd_err`; the row is unchanged.
- PRECHARGE: `A10`=1 closes all banks; `A10`=0 closes bank `BA`. It is legal on closed banks and during a burst; the burst still completes.
- LOAD_MODE: `A[6:4]` sets the CAS latency. Only 2 or 3 are accepted. Any other value raises `cmd_err` and leaves the latency unchanged. Other mode fields are ignored; burst length is fixed at 4.
- AUTO_REFRESH: no data effect. It raises `cmd_err` if any bank is open.
- WRITE: requires bank `BA` open and no burst in progress.
  - The beat-0 nibble is sampled on the same edge as the command; beats 1–3 on the next three edges.
  - Nibble address = `{BA, row, A[COL_W-1:2], beat}`.
  - Nibble order matches the controller packing: beat 0 = bits[3:0] … beat 3 = bits[15:12].
- READ: requires bank `BA` open and no burst in progress. It drives the 4 stored nibbles, beat 0 first.
- Auto-precharge: `A10`=1 on a READ or WRITE closes the bank on the edge of its last beat.
- Busy: from a WRITE command edge through the beat-3 edge, and from a READ command edge through the last read beat. A READ or WRITE while busy, or to a closed bank, raises `cmd_err`, is ignored, and the current burst continues.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `sdr_DQ` high-Z, `cmd_err` 0, `row_open` 0, all banks closed, latency = `DEF_CAS`, burst state idle.
- WRITE sampled at edge N: data is captured at edges N, N+1, N+2, N+3. A READ or WRITE is next accepted at N+4.
- READ sampled at edge N with latency CL:
  - beat k is valid at edge N+CL+k, for k = 0..3.
  - `sdr_DQ` is driven `tDLY` after edge N+CL−1.
  - It is released to Z `tDLY` after edge N+CL+3.
  - A READ or WRITE is next accepted at edge N+CL+4.
- `cmd_err` is asserted `tDLY` after the offending edge for exactly one cycle.
- `row_open` updates `tDLY` after the ACTIVE or PRECHARGE edge.
- A LOAD_MODE while a read is pending does not alter that read's latency; the latency is latched at the READ edge.
- Reset mid-burst: `sdr_DQ` goes to Z `tDLY` after `reset` rises. The in-flight write is abandoned; beats already written persist.

## Structure
- Command encodings, `c_*`-style command constants, and `tDLY` go in the shared `sdr_para` include alongside the controller's state constants.
- Sub-module `sdr_rd_pipe`: a read-latency shift register carrying {valid, beat, address} for CL ≤ 3. It emits the drive-enable and the read address per beat.
- Top level holds the decode, bank row table, write beat counter, nibble array, and tristate.

## Test plan
- Reset; LOAD_MODE `A`=0x030; ACTIVE bank0 row 5; WRITE col 0x10 with nibbles 4,3,2,1; READ col 0x10 at edge N -> `sdr_DQ` = 4,3,2,1 at edges N+3..N+6, Z before and after, `cmd_err` never set.
- LOAD_MODE `A`=0x020, repeat the READ -> beat 0 at N+2, release after N+5.
- READ to closed bank 2 -> `cmd_err` pulses for 1 cycle, `sdr_DQ` stays Z.
- WRITE issued at N+4 during a CL3 read begun at N -> `cmd_err`, read beats unaffected, memory unchanged.
- WRITE with `A10`=1 -> `row_open` drops after beat 3; following READ to that bank -> `cmd_err`.
- Assert `reset` at read beat 1 -> `sdr_DQ` Z within `tDLY`, `row_open` 0, latency back to 3; LOAD_MODE `A`=0x010 afterwards -> `cmd_err`, latency stays 3.
